// File: rtl/regfile.sv
// 32 x DATA_WIDTH register file, two combinational read ports, one write port; x0 hardwired to 0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module regfile #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [4:0]            rs_addr_a_i,
    output logic [DATA_WIDTH-1:0] rs_data_a_o,
    input  logic [4:0]            rs_addr_b_i,
    output logic [DATA_WIDTH-1:0] rs_data_b_o,
    input  logic [4:0]            rd_addr_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  rd_we_i
);

    // x0 has no storage; index 0 of the array is never instantiated.
    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
    logic [NUM_REGS-1:1]   we_dec;
    logic [DATA_WIDTH-1:0] stored_a;
    logic [DATA_WIDTH-1:0] stored_b;

    always_comb begin
        we_dec = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            we_dec[i] = rd_we_i && (rd_addr_i == 5'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (we_dec[i]) begin
                    regs_q[i] <= rd_data_i;
                end
            end
        end
    end

    always_comb begin
        stored_a = '0;
        stored_b = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (rs_addr_a_i == 5'(i)) begin
                stored_a = regs_q[i];
            end
            if (rs_addr_b_i == 5'(i)) begin
                stored_b = regs_q[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_ok;
    logic fwd_a;
    logic fwd_b;

    // Forwarding never fires during reset, without enable, or for x0.
    assign fwd_ok = rst_ni && rd_we_i && (rd_addr_i != 5'd0);
    assign fwd_a  = fwd_ok && (rs_addr_a_i == rd_addr_i);
    assign fwd_b  = fwd_ok && (rs_addr_b_i == rd_addr_i);

    always_comb begin
        rs_data_a_o = fwd_a ? rd_data_i : stored_a;
        rs_data_b_o = fwd_b ? rd_data_i : stored_b;
    end
`else
    always_comb begin
        rs_data_a_o = stored_a;
        rs_data_b_o = stored_b;
    end
`endif

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// compared against an array model; honours REGFILE_BYPASS_EN the same way as the design.
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  raddr_a;
    logic [31:0] rdata_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_b;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;

    logic [31:0] model [32];
    int          n_tests;
    int          n_fail;

    regfile dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rs_addr_a_i (raddr_a),
        .rs_data_a_o (rdata_a),
        .rs_addr_b_i (raddr_b),
        .rs_data_b_o (rdata_b),
        .rd_addr_i   (waddr),
        .rd_data_i   (wdata),
        .rd_we_i     (we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Value a read port should show right now, from the model and the current write inputs.
    function automatic logic [31:0] exp_read(input logic [4:0] ra);
`ifdef REGFILE_BYPASS_EN
        if (rst_n && we && waddr != 5'd0 && ra == waddr) return wdata;
`endif
        return model[ra];
    endfunction

    task automatic check_reads(input string tag);
        #1;
        check_eq({tag, "_a"}, rdata_a, exp_read(raddr_a));
        check_eq({tag, "_b"}, rdata_b, exp_read(raddr_b));
    endtask

    // Advance one rising edge and apply the same update to the model.
    task automatic cycle();
        logic        r;
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        r = rst_n;
        w = we;
        a = waddr;
        d = wdata;
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (w && a != 5'd0) begin
            model[a] = d;
        end
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        rst_n   = 1'b0;
        we      = 1'b0;
        waddr   = 5'd0;
        wdata   = 32'd0;
        raddr_a = 5'd0;
        raddr_b = 5'd0;

        // Reset sweep
        for (int i = 0; i < 5; i++) cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(31 - i);
            #1;
            check_eq("reset_sweep_a", rdata_a, 32'd0);
            check_eq("reset_sweep_b", rdata_b, 32'd0);
        end

        // Bulk load x[i] = i-4
        we = 1'b1;
        for (int i = 4; i <= 30; i++) begin
            waddr = 5'(i);
            wdata = 32'(i - 4);
            cycle();
        end
        we      = 1'b0;
        raddr_a = 5'd0;
        raddr_b = 5'd16;
        #1;
        check_eq("bulk_a0", rdata_a, 32'd0);
        check_eq("bulk_b16", rdata_b, 32'd12);
        raddr_b = 5'd30;
        #1;
        check_eq("bulk_b30", rdata_b, 32'd26);
        raddr_b = 5'd31;
        #1;
        check_eq("bulk_b31", rdata_b, 32'd0);

        // x0 protection
        we    = 1'b1;
        waddr = 5'd0;
        wdata = 32'hDEADBEEF;
        raddr_a = 5'd0;
        raddr_b = 5'd0;
        check_reads("x0_same_cycle");
        cycle();
        we = 1'b0;
        #1;
        check_eq("x0_a", rdata_a, 32'd0);
        check_eq("x0_b", rdata_b, 32'd0);

        // Write enable gating
        we      = 1'b0;
        waddr   = 5'd5;
        wdata   = 32'h1234;
        raddr_a = 5'd5;
        raddr_b = 5'd5;
        cycle();
        #1;
        check_eq("we_off_x5", rdata_a, 32'd1);
        we = 1'b1;
        cycle();
        we = 1'b0;
        #1;
        check_eq("we_on_a", rdata_a, 32'h1234);
        check_eq("we_on_b", rdata_b, 32'h1234);

        // Reset priority over write
        rst_n   = 1'b0;
        we      = 1'b1;
        waddr   = 5'd7;
        wdata   = 32'hFFFF_FFFF;
        raddr_a = 5'd7;
        raddr_b = 5'd16;
        check_reads("rst_prio_pre");
        cycle();
        rst_n = 1'b1;
        we    = 1'b0;
        #1;
        check_eq("rst_prio_x7", rdata_a, 32'd0);
        check_eq("rst_prio_x16", rdata_b, 32'd0);

        // Forwarding
        we    = 1'b1;
        waddr = 5'd9;
        wdata = 32'd1;
        cycle();
        wdata   = 32'd2;
        raddr_a = 5'd9;
        raddr_b = 5'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("fwd_same_cycle", rdata_a, 32'd2);
`else
        check_eq("fwd_same_cycle", rdata_a, 32'd1);
`endif
        cycle();
        we = 1'b0;
        #1;
        check_eq("fwd_after_edge", rdata_a, 32'd2);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            we    = ($urandom_range(0, 3) != 0);
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom();
            raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr_b = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            check_reads("rand_pre");
            cycle();
            check_reads("rand_post");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
